// File: rtl/ram_access_unit.sv
// Data RAM plus load/store FSM for WRITE_RAM_OP (0x91) and READ_RAM_OP (0x92); done two cycles after accept.
// Defining RAM_BOUNDS_CHECK_EN allows DEPTH < 2**ADDR_W, and an out-of-range access then pulses fault.
module ram_access_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           opcode,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] reg_read_data,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  reg_write_en,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam logic [7:0] WRITE_RAM_OP = 8'h91;
  localparam logic [7:0] READ_RAM_OP  = 8'h92;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WB,
    S_WR,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    is_store, is_load, accept;
  logic                    oob;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  // Only the high opcode byte selects the operation.
  logic unused_opcode_lo;
  assign unused_opcode_lo = ^opcode[7:0];

  assign is_store = (opcode[15:8] == WRITE_RAM_OP);
  assign is_load  = (opcode[15:8] == READ_RAM_OP);
  assign accept   = (state_q == S_IDLE) && start && (is_store || is_load);

`ifdef RAM_BOUNDS_CHECK_EN
  logic oob_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oob_q <= 1'b0;
    end else if (accept) begin
      oob_q <= ({1'b0, mem_addr} >= (ADDR_W+1)'(DEPTH));
    end
  end

  assign oob = oob_q;
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ram_we       = 1'b0;
    reg_write_en = 1'b0;
    done         = 1'b0;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = mem_addr;
          if (is_store) begin
            wdata_d = reg_read_data;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (!oob) begin
          rdata_d = ram[addr_q];
        end
        state_d = S_RD_WB;
      end
      S_RD_WB: begin
        reg_write_en = !oob;
        done         = 1'b1;
        state_d      = S_IDLE;
      end
      S_WR: begin
        ram_we  = !oob;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    fault = done & oob;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The write strobe comes from the async-reset state, so a reset before the write edge drops the store.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[addr_q] <= wdata_q;
    end
  end

  assign reg_write_data = rdata_q;

endmodule

// File: tb/tb_ram_access_unit.sv
// Bench for ram_access_unit: directed steps plus randomized load/store traffic against an array model.
module tb_ram_access_unit;

  localparam int DW = 16;
  localparam int AW = 8;
`ifdef RAM_BOUNDS_CHECK_EN
  localparam int DEPTH = 200;
`else
  localparam int DEPTH = 256;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   opcode = 16'h0000;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] reg_read_data = '0;
  logic [DW-1:0] reg_write_data;
  logic          reg_write_en;
  logic          busy;
  logic          done;
  logic          fault;

  ram_access_unit #(
    .DATA_WIDTH(DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .start         (start),
    .mem_addr      (mem_addr),
    .reg_read_data (reg_read_data),
    .reg_write_data(reg_write_data),
    .reg_write_en  (reg_write_en),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  // Reference: what each RAM word should hold, and the last word handed to the register file.
  logic [DW-1:0] model [256];
  logic [DW-1:0] last_rd;
  int            n_pass   = 0;
  int            n_fail   = 0;
  int            n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we"}, 32'(reg_write_en), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_wdata"}, 32'(reg_write_data), 32'(last_rd));
  endtask

  // One complete operation; poke re-pulses start with the other opcode while busy.
  task automatic do_op(input bit store, input logic [7:0] addr, input logic [15:0] data, input bit poke);
    bit oob;
    oob      = (int'(addr) >= DEPTH);
    opcode   = {(store ? 8'h91 : 8'h92), 8'($urandom)};
    mem_addr = addr;
    if (store) reg_read_data = data;
    else       reg_read_data = 'x;
    start    = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    mem_addr      = 8'($urandom);
    reg_read_data = 16'($urandom);
    chk("op_n1_busy", 32'(busy), 32'd1);
    chk("op_n1_done", 32'(done), 32'd0);
    chk("op_n1_we", 32'(reg_write_en), 32'd0);
    if (poke) begin
      start  = 1'b1;
      opcode = {(store ? 8'h92 : 8'h91), 8'h00};
    end
    @(posedge clk); #1;
    start  = 1'b0;
    opcode = {(store ? 8'h91 : 8'h92), 8'h00};
    if (!store && !oob) last_rd = model[addr];
    chk("op_done", 32'(done), 32'd1);
    chk("op_busy", 32'(busy), 32'd1);
    chk("op_we", 32'(reg_write_en), 32'(!store && !oob));
    chk("op_fault", 32'(fault), 32'(oob));
    chk("op_wdata", 32'(reg_write_data), 32'(last_rd));
    if (store && !oob) model[addr] = data;
    @(posedge clk); #1;
    chk_idle("op_after");
  endtask

  initial begin
    logic [7:0] bad_ops [5];
    bad_ops = '{8'h22, 8'h90, 8'h93, 8'h00, 8'h19};
    last_rd = '0;

    // Reset state, checked before any clock edge.
    #1;
    chk_idle("reset0");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle("reset_rel");

    // Fill every address so later loads have defined expectations.
    for (int i = 0; i < 256; i++) do_op(1'b1, 8'(i), 16'($urandom), 1'b0);

    // Store then load of one address.
    do_op(1'b1, 8'h05, 16'hBEEF, 1'b0);
    do_op(1'b0, 8'h05, 16'h0000, 1'b0);
    chk("beef_held", 32'(reg_write_data), 32'h0000BEEF);

    // Back-to-back issue at both address extremes.
    do_op(1'b1, 8'hFF, 16'h1234, 1'b0);
    do_op(1'b1, 8'h00, 16'h0001, 1'b0);
    do_op(1'b0, 8'hFF, 16'h0000, 1'b0);
    do_op(1'b0, 8'h00, 16'h0000, 1'b0);

    // Unrecognised opcodes are ignored.
    foreach (bad_ops[k]) begin
      opcode   = {bad_ops[k], 8'($urandom)};
      mem_addr = 8'($urandom);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk_idle("badop_n1");
      @(posedge clk); #1;
      chk_idle("badop_n2");
    end

    // start while busy is neither queued nor able to change the latched op.
    do_op(1'b1, 8'h33, 16'hC0DE, 1'b1);
    do_op(1'b0, 8'h33, 16'h0000, 1'b1);
    @(posedge clk); #1;
    chk_idle("poke_idle");

    // Asynchronous reset in the write-back cycle of a load.
    opcode   = 16'h9200;
    mem_addr = 8'h05;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rstld_done", 32'(done), 32'd1);
    chk("rstld_we", 32'(reg_write_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    last_rd = '0;
    chk_idle("rstld_async");
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle("rstld_rel");

    // Reset right after a store is accepted abandons the store.
    do_op(1'b1, 8'h10, 16'h5555, 1'b0);
    opcode        = 16'h9100;
    mem_addr      = 8'h10;
    reg_read_data = 16'hAAAA;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rstst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    last_rd = '0;
    chk_idle("rstst_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(1'b0, 8'h10, 16'h0000, 1'b0);
    chk("rstst_old", 32'(reg_write_data), 32'h00005555);

`ifdef RAM_BOUNDS_CHECK_EN
    // Out-of-range accesses: fault with done, no write-back, no RAM write.
    do_op(1'b0, 8'hC8, 16'h0000, 1'b0);
    do_op(1'b1, 8'hC8, 16'hDEAD, 1'b0);
    do_op(1'b0, 8'hC7, 16'h0000, 1'b0);
    do_op(1'b1, 8'hFF, 16'hDEAD, 1'b0);
`endif

    // Randomized traffic.
    repeat (150) begin
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Final sweep: every in-range word matches the model.
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 8'(i), 16'h0000, 1'b0);

    if (n_fail != 0) $display("summary: %0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
